// File: rtl/nfc_bus_cycle_engine_pkg.sv
// Shared types and default timing for the NAND bus cycle engine.
package nfc_bus_cycle_engine_pkg;

  // Primitive bus cycle requested by the sequencer; encodings 5..7 are no-ops.
  typedef enum logic [2:0] {
    CYC_CMD     = 3'd0,
    CYC_ADDR    = 3'd1,
    CYC_WDATA   = 3'd2,
    CYC_RDATA   = 3'd3,
    CYC_WAIT_RB = 3'd4
  } nfc_cyc_e;

  // Engine phases; every phase except IDLE and RESP is timed by the shared counter.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_SETUP = 4'd1,
    ST_WE_LO = 4'd2,
    ST_WE_HI = 4'd3,
    ST_RE_LO = 4'd4,
    ST_RE_HI = 4'd5,
    ST_WB    = 4'd6,
    ST_RB    = 4'd7,
    ST_RESP  = 4'd8
  } nfc_state_e;

  localparam int unsigned DEF_T_SETUP   = 32'd1;
  localparam int unsigned DEF_T_WP      = 32'd2;
  localparam int unsigned DEF_T_WH      = 32'd2;
  localparam int unsigned DEF_T_RP      = 32'd2;
  localparam int unsigned DEF_T_REH     = 32'd2;
  localparam int unsigned DEF_T_WB      = 32'd10;
  localparam int unsigned DEF_BUSY_TOUT = 32'd4096;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Cycle types that put a byte on DIO and strobe WE_n.
  function automatic logic is_write_cyc(input logic [2:0] t);
    return (t == CYC_CMD) || (t == CYC_ADDR) || (t == CYC_WDATA);
  endfunction

endpackage

// File: rtl/nfc_bus_cycle_engine_if.sv
// Request/response handshake between the command sequencer and the bus cycle engine.
interface nfc_bus_cycle_engine_if;
  logic       cyc_valid;
  logic       cyc_ready;
  logic [2:0] cyc_type;
  logic [7:0] cyc_data;
  logic       cyc_last;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_tout;

  modport master (
    output cyc_valid, cyc_type, cyc_data, cyc_last,
    input  cyc_ready, rsp_valid, rsp_data, rsp_tout
  );

  modport slave (
    input  cyc_valid, cyc_type, cyc_data, cyc_last,
    output cyc_ready, rsp_valid, rsp_data, rsp_tout
  );
endinterface

// File: rtl/nfc_bus_cycle_engine_sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs (used for R_nB).
module nfc_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q;
  logic sync_q;

  // Two-stage capture; both stages reset to RST_VAL so no false edge follows reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/nfc_bus_cycle_engine.sv
// NAND pin-level bus cycle engine: turns one primitive request into CE_n/CLE/ALE/WE_n/RE_n/DIO
// activity with parameterised timing and returns a single-cycle response.
module nfc_bus_cycle_engine
  import nfc_bus_cycle_engine_pkg::*;
#(
  parameter int unsigned T_SETUP   = DEF_T_SETUP,
  parameter int unsigned T_WP      = DEF_T_WP,
  parameter int unsigned T_WH      = DEF_T_WH,
  parameter int unsigned T_RP      = DEF_T_RP,
  parameter int unsigned T_REH     = DEF_T_REH,
  parameter int unsigned T_WB      = DEF_T_WB,
  parameter int unsigned BUSY_TOUT = DEF_BUSY_TOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  nfc_bus_cycle_engine_if.slave bus,
  inout  wire  [7:0]            DIO,
  output logic                  CLE,
  output logic                  ALE,
  output logic                  WE_n,
  output logic                  RE_n,
  output logic                  CE_n,
  input  logic                  R_nB
);
  localparam int unsigned MAX_T = max_u(max_u(max_u(T_SETUP, T_WP), max_u(T_WH, T_RP)),
                                        max_u(max_u(T_REH, T_WB), BUSY_TOUT));
  localparam int unsigned CNT_W = $clog2(MAX_T + 32'd1);

  if ((T_SETUP < 32'd1) || (T_WP < 32'd1) || (T_WH < 32'd1) || (T_RP < 32'd1) ||
      (T_REH < 32'd1) || (T_WB < 32'd1) || (BUSY_TOUT < 32'd1)) begin : g_bad_timing
    $error("nfc_bus_cycle_engine: all timing parameters must be >= 1");
  end

  nfc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       type_q, type_d;
  logic [7:0]       data_q, data_d;
  logic             last_q, last_d;
  logic             ce_n_q, ce_n_d, cle_q, cle_d, ale_q, ale_d;
  logic             we_n_q, we_n_d, re_n_q, re_n_d, oe_q, oe_d;
  logic [7:0]       dout_q, dout_d, rsp_data_q, rsp_data_d;
  logic             cyc_ready_q, cyc_ready_d, rsp_valid_q, rsp_valid_d, rsp_tout_q, rsp_tout_d;
  logic             rnb_s, accept_s, cnt_zero_s, wr_phase_s;

  nfc_sync2 #(.RST_VAL(1'b1)) u_rnb_sync (.clk(clk), .rst(rst), .d(R_nB), .q(rnb_s));

  assign accept_s   = bus.cyc_valid & cyc_ready_q;
  assign cnt_zero_s = (cnt_q == '0);

  // State register; an asynchronous reset drops any in-flight cycle without a response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: each timed phase ends when the shared down-counter reaches zero.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!accept_s)                                                     state_d = ST_IDLE;
        else if (is_write_cyc(bus.cyc_type) || bus.cyc_type == CYC_RDATA) state_d = ST_SETUP;
        else if (bus.cyc_type == CYC_WAIT_RB)                              state_d = ST_WB;
        else                                                               state_d = ST_RESP;
      end
      ST_SETUP: begin
        if (!cnt_zero_s)              state_d = ST_SETUP;
        else if (is_write_cyc(type_q)) state_d = ST_WE_LO;
        else                          state_d = ST_RE_LO;
      end
      ST_WE_LO: state_d = cnt_zero_s ? ST_WE_HI : ST_WE_LO;
      ST_WE_HI: state_d = cnt_zero_s ? ST_RESP  : ST_WE_HI;
      ST_RE_LO: state_d = cnt_zero_s ? ST_RE_HI : ST_RE_LO;
      ST_RE_HI: state_d = cnt_zero_s ? ST_RESP  : ST_RE_HI;
      ST_WB:    state_d = cnt_zero_s ? ST_RB    : ST_WB;
      // Ready wins over timeout when both happen in the final RB cycle.
      ST_RB:    state_d = (rnb_s || cnt_zero_s) ? ST_RESP : ST_RB;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Shared counter: load phase length minus one on entry, then count down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      case (state_d)
        ST_SETUP: cnt_d = CNT_W'(T_SETUP - 32'd1);
        ST_WE_LO: cnt_d = CNT_W'(T_WP - 32'd1);
        ST_WE_HI: cnt_d = CNT_W'(T_WH - 32'd1);
        ST_RE_LO: cnt_d = CNT_W'(T_RP - 32'd1);
        ST_RE_HI: cnt_d = CNT_W'(T_REH - 32'd1);
        ST_WB:    cnt_d = CNT_W'(T_WB - 32'd1);
        ST_RB:    cnt_d = CNT_W'(BUSY_TOUT - 32'd1);
        default:  cnt_d = '0;
      endcase
    end else if (!cnt_zero_s) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output decode from the next state so every pin is a flop aligned with the state register.
  always_comb begin
    if (accept_s) begin
      type_d = bus.cyc_type;
      data_d = bus.cyc_data;
      last_d = bus.cyc_last;
    end else begin
      type_d = type_q;
      data_d = data_q;
      last_d = last_q;
    end
    wr_phase_s  = (state_d == ST_SETUP) || (state_d == ST_WE_LO) || (state_d == ST_WE_HI);
    cle_d       = wr_phase_s && (type_d == CYC_CMD);
    ale_d       = wr_phase_s && (type_d == CYC_ADDR);
    oe_d        = wr_phase_s && is_write_cyc(type_d);
    dout_d      = data_d;
    we_n_d      = (state_d != ST_WE_LO);
    re_n_d      = (state_d != ST_RE_LO);
    cyc_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    rsp_tout_d  = (state_q == ST_RB) && (state_d == ST_RESP) && !rnb_s;
    // Chip stays selected between cycles; only a completed "last" cycle deselects it.
    if (state_d == ST_SETUP)                ce_n_d = 1'b0;
    else if (state_q == ST_RESP && last_q)  ce_n_d = 1'b1;
    else                                    ce_n_d = ce_n_q;
    // Read byte is taken on the edge that ends the final RE_n low cycle.
    if (state_q == ST_RE_LO && cnt_zero_s)  rsp_data_d = DIO;
    else                                    rsp_data_d = rsp_data_q;
  end

  // Request latch, pin and response flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      type_q      <= 3'd0;
      data_q      <= 8'h00;
      last_q      <= 1'b0;
      ce_n_q      <= 1'b1;
      cle_q       <= 1'b0;
      ale_q       <= 1'b0;
      we_n_q      <= 1'b1;
      re_n_q      <= 1'b1;
      oe_q        <= 1'b0;
      dout_q      <= 8'h00;
      cyc_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_tout_q  <= 1'b0;
    end else begin
      type_q      <= type_d;
      data_q      <= data_d;
      last_q      <= last_d;
      ce_n_q      <= ce_n_d;
      cle_q       <= cle_d;
      ale_q       <= ale_d;
      we_n_q      <= we_n_d;
      re_n_q      <= re_n_d;
      oe_q        <= oe_d;
      dout_q      <= dout_d;
      cyc_ready_q <= cyc_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tout_q  <= rsp_tout_d;
    end
  end

  assign DIO           = oe_q ? dout_q : 8'hzz;
  assign CLE           = cle_q;
  assign ALE           = ale_q;
  assign WE_n          = we_n_q;
  assign RE_n          = re_n_q;
  assign CE_n          = ce_n_q;
  assign bus.cyc_ready = cyc_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_tout  = rsp_tout_q;
endmodule
